// File: rtl/pll_cfg_writer.sv
// Sequences a PLL reconfiguration over Avalon-MM: mode write, host entries,
// start write, status poll and lock wait, with a saturating timeout on the last two.
module pll_cfg_writer #(
  parameter int unsigned TIMEOUT   = 65535,
  parameter logic [31:0] MODE_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ent_valid,
  output logic        ent_ready,
  input  logic [5:0]  ent_addr,
  input  logic [31:0] ent_data,
  input  logic        ent_last,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MODE_WR   = 3'd1;
  localparam logic [2:0] ENT_WAIT  = 3'd2;
  localparam logic [2:0] ENT_WR    = 3'd3;
  localparam logic [2:0] START_WR  = 3'd4;
  localparam logic [2:0] POLL_RD   = 3'd5;
  localparam logic [2:0] LOCK_WAIT = 3'd6;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gap_q, gap_d;

  logic [15:0] cnt_inc;
  logic        timer_active;
  logic        timeout_hit;

  // Only the ready bit of the status word matters.
  logic unused_readdata;
  assign unused_readdata = ^mgmt_readdata[31:1];

  always_comb begin
    timer_active = (state_q == POLL_RD) || (state_q == LOCK_WAIT);
    cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    timeout_hit  = timer_active && ({16'd0, cnt_inc} >= TIMEOUT_W);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (ent_valid) state_d = MODE_WR;
      end
      MODE_WR: begin
        if (!mgmt_waitrequest) state_d = ENT_WAIT;
      end
      ENT_WAIT: begin
        if (ent_valid) begin
          addr_d  = ent_addr;
          data_d  = ent_data;
          last_d  = ent_last;
          state_d = ENT_WR;
        end
      end
      ENT_WR: begin
        if (!mgmt_waitrequest) state_d = last_q ? START_WR : ENT_WAIT;
      end
      START_WR: begin
        if (!mgmt_waitrequest) begin
          cnt_d   = 16'd0;
          gap_d   = 1'b0;
          state_d = POLL_RD;
        end
      end
      POLL_RD: begin
        cnt_d = cnt_inc;
        // Timeout wins over a status completion in the same cycle.
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (gap_q) begin
          gap_d = 1'b0;
        end else if (!mgmt_waitrequest) begin
          if (mgmt_readdata[0]) state_d = LOCK_WAIT;
          else                  gap_d   = 1'b1;
        end
      end
      LOCK_WAIT: begin
        cnt_d = cnt_inc;
        if (timeout_hit || pll_locked) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so they read zero for the whole reset cycle.
  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    ent_ready      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    if (rst_n) begin
      ent_ready = (state_q == ENT_WAIT);
      busy      = (state_q != IDLE);
      done      = (state_q == LOCK_WAIT) && pll_locked && !timeout_hit;
      error     = timeout_hit;
      case (state_q)
        MODE_WR: begin
          mgmt_write     = 1'b1;
          mgmt_writedata = MODE_WORD;
        end
        ENT_WR: begin
          mgmt_write     = 1'b1;
          mgmt_address   = addr_q;
          mgmt_writedata = data_q;
        end
        START_WR: begin
          mgmt_write   = 1'b1;
          mgmt_address = 6'd2;
        end
        POLL_RD: begin
          mgmt_read    = !gap_q;
          mgmt_address = 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 6'd0;
      data_q  <= 32'd0;
      last_q  <= 1'b0;
      cnt_q   <= 16'd0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Directed bench for pll_cfg_writer: write ordering, stalls, status polling,
// timeout priority and mid-transfer reset, with hand-computed expectations.
module tb_pll_cfg_writer;

  logic        clk;
  logic        rst_n;
  logic        ent_valid;
  logic        ent_ready;
  logic [5:0]  ent_addr;
  logic [31:0] ent_data;
  logic        ent_last;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  pll_cfg_writer #(.TIMEOUT(20), .MODE_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ent_valid(ent_valid), .ent_ready(ent_ready),
    .ent_addr(ent_addr), .ent_data(ent_data), .ent_last(ent_last),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic wr, input logic rd,
                          input logic [5:0] addr, input logic [31:0] data);
    checkOutput({tag, ".write"}, 32'(mgmt_write), 32'(wr));
    checkOutput({tag, ".read"},  32'(mgmt_read),  32'(rd));
    if (wr || rd) checkOutput({tag, ".addr"}, 32'(mgmt_address), 32'(addr));
    if (wr)       checkOutput({tag, ".data"}, mgmt_writedata, data);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".outs"},
                {21'd0, mgmt_write, mgmt_read, ent_ready, busy, done, error, mgmt_address}, 32'd0);
    checkOutput({tag, ".wdata"}, mgmt_writedata, 32'd0);
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] addr,
                               input logic [31:0] data, input logic last);
    ent_valid = valid;
    ent_addr  = addr;
    ent_data  = data;
    ent_last  = last;
  endtask

  // From IDLE with waitrequest low: leaves the DUT in ENT_WR with the entry latched.
  task automatic startSeq(input logic [5:0] addr, input logic [31:0] data, input logic last);
    applyStimulus(1'b1, addr, data, last);
    tick;
    tick;
    tick;
    applyStimulus(1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int done_cyc;
    int err_k;
    int err_cnt;
    int done_cnt;
    logic busy_after;
    logic accept;
    logic [6:0] rd_pat;

    rst_n = 1'b0;
    mgmt_waitrequest = 1'b0;
    mgmt_readdata = 32'd1;
    pll_locked = 1'b1;
    applyStimulus(1'b1, 6'd4, 32'h404, 1'b0);
    tick;
    settle;
    checkAllZero("reset_hold");
    tick;
    settle;
    checkAllZero("reset_hold2");

    // Two entries, zero wait states.
    rst_n = 1'b1;
    settle;
    checkOutput("seq.idle_ready", 32'(ent_ready), 32'd0);
    checkOutput("seq.idle_busy", 32'(busy), 32'd0);
    checkBus("seq.idle", 1'b0, 1'b0, 6'd0, 32'd0);
    tick; settle;
    checkBus("seq.mode", 1'b1, 1'b0, 6'd0, 32'h0);
    checkOutput("seq.mode_busy", 32'(busy), 32'd1);
    checkOutput("seq.mode_ready", 32'(ent_ready), 32'd0);
    tick; settle;
    checkOutput("seq.wait1_ready", 32'(ent_ready), 32'd1);
    checkBus("seq.wait1", 1'b0, 1'b0, 6'd0, 32'd0);
    tick;
    applyStimulus(1'b1, 6'd5, 32'h0002_0303, 1'b1);
    settle;
    checkBus("seq.ent1", 1'b1, 1'b0, 6'd4, 32'h404);
    checkOutput("seq.ent1_ready", 32'(ent_ready), 32'd0);
    tick; settle;
    checkOutput("seq.wait2_ready", 32'(ent_ready), 32'd1);
    tick;
    applyStimulus(1'b0, 6'd0, 32'd0, 1'b0);
    settle;
    checkBus("seq.ent2", 1'b1, 1'b0, 6'd5, 32'h0002_0303);
    tick; settle;
    checkBus("seq.start", 1'b1, 1'b0, 6'd2, 32'h0);
    tick; settle;
    checkBus("seq.poll", 1'b0, 1'b1, 6'd1, 32'h0);
    tick; settle;
    checkOutput("seq.done", 32'(done), 32'd1);
    checkOutput("seq.done_busy", 32'(busy), 32'd1);
    checkBus("seq.lock", 1'b0, 1'b0, 6'd0, 32'd0);
    tick; settle;
    checkOutput("seq.done_once", 32'(done), 32'd0);
    checkOutput("seq.busy_clr", 32'(busy), 32'd0);

    // Minimum latency: ent_valid at cycle 0, done at cycle 6.
    applyStimulus(1'b1, 6'd3, 32'h33, 1'b1);
    done_cyc = -1;
    for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
      settle;
      if (done) done_cyc = cyc;
      accept = ent_ready;
      tick;
      if (accept) applyStimulus(1'b0, 6'd0, 32'd0, 1'b0);
    end
    checkOutput("latency.done_cycle", 32'(done_cyc), 32'd6);
    settle;
    checkOutput("latency.idle", 32'(busy), 32'd0);

    // Five-cycle stall on an entry write, then a four-read status poll.
    startSeq(6'd7, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      mgmt_waitrequest = (i < 5);
      settle;
      checkBus($sformatf("stall.c%0d", i), 1'b1, 1'b0, 6'd7, 32'hDEAD_BEEF);
      tick;
    end
    mgmt_waitrequest = 1'b0;
    settle;
    checkBus("stall.next_is_start", 1'b1, 1'b0, 6'd2, 32'h0);
    tick;
    rd_pat = 7'b1010101;
    for (int i = 0; i < 7; i++) begin
      mgmt_readdata = (i == 6) ? 32'd1 : 32'hFFFF_FFFE;
      settle;
      checkOutput($sformatf("poll.rd%0d", i), 32'(mgmt_read), 32'(rd_pat[i]));
      checkOutput($sformatf("poll.wr%0d", i), 32'(mgmt_write), 32'd0);
      tick;
    end
    pll_locked = 1'b0;
    settle;
    checkOutput("poll.lock_wait_busy", 32'(busy), 32'd1);
    checkOutput("poll.lock_wait_read", 32'(mgmt_read), 32'd0);
    checkOutput("poll.lock_wait_done", 32'(done), 32'd0);
    tick;
    pll_locked = 1'b1;
    settle;
    checkOutput("poll.done", 32'(done), 32'd1);
    tick;

    // Timeout with an address-0 entry; lock arrives in the timeout cycle.
    pll_locked = 1'b0;
    mgmt_readdata = 32'd1;
    startSeq(6'd0, 32'h1234_5678, 1'b1);
    settle;
    checkBus("tmo.ent_addr0", 1'b1, 1'b0, 6'd0, 32'h1234_5678);
    tick; settle;
    checkBus("tmo.start", 1'b1, 1'b0, 6'd2, 32'h0);
    tick;
    err_k = -1; err_cnt = 0; done_cnt = 0; busy_after = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      pll_locked = (k == 20);
      settle;
      if (error) begin
        err_cnt++;
        if (err_k < 0) err_k = k;
      end
      if (done) done_cnt++;
      if (k == 21) busy_after = busy;
      tick;
    end
    checkOutput("tmo.error_cycle", 32'(err_k), 32'd20);
    checkOutput("tmo.error_pulses", 32'(err_cnt), 32'd1);
    checkOutput("tmo.no_done", 32'(done_cnt), 32'd0);
    checkOutput("tmo.busy_fell", 32'(busy_after), 32'd0);

    // Reset during a stalled entry write.
    pll_locked = 1'b1;
    startSeq(6'd9, 32'hA5A5_A5A5, 1'b1);
    mgmt_waitrequest = 1'b1;
    settle;
    checkBus("rst.stalled", 1'b1, 1'b0, 6'd9, 32'hA5A5_A5A5);
    rst_n = 1'b0;
    settle;
    checkAllZero("rst.asserted");
    tick; settle;
    checkAllZero("rst.after_edge");
    rst_n = 1'b1;
    mgmt_waitrequest = 1'b0;
    applyStimulus(1'b1, 6'd9, 32'h1, 1'b1);
    settle;
    checkOutput("rst.idle_busy", 32'(busy), 32'd0);
    tick; settle;
    checkBus("rst.fresh_mode", 1'b1, 1'b0, 6'd0, 32'h0);
    checkOutput("rst.fresh_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 6'd0, 32'd0, 1'b0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_cfg_writer.md
PLL_CFG_WRITER -- requirements
Module: pll_cfg_writer

Interface
REQ-001 Parameter TIMEOUT, default 65535: maximum cycles allowed for the combined status-poll and lock-wait phases before the block aborts.
REQ-002 Parameter MODE_WORD, default 32'h0000_0000: data written to mode register (address 0); this value selects waitrequest mode.
REQ-003 clk  input  1  management clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ent_valid  input  1  the host presents a reconfiguration entry.
REQ-006 ent_ready  output  1  the block accepts the entry this cycle.
REQ-007 ent_addr  input  6  PLL reconfig register address of the entry.
REQ-008 ent_data  input  32  data for the entry.
REQ-009 ent_last  input  1  marks the final entry of the sequence.
REQ-010 mgmt_address  output  6  Avalon-MM address to the PLL reconfig core.
REQ-011 mgmt_write  output  1  Avalon-MM write strobe.
REQ-012 mgmt_read  output  1  Avalon-MM read strobe.
REQ-013 mgmt_writedata  output  32  Avalon-MM write data.
REQ-014 mgmt_readdata  input  32  Avalon-MM read data, valid in the cycle in which a read completes.
REQ-015 mgmt_waitrequest  input  1  while high, the current transfer is stalled.
REQ-016 pll_locked  input  1  lock indication from the PLL, already synchronous to clk.
REQ-017 busy  output  1  high from sequence start until done or error.
REQ-018 done  output  1  one-cycle pulse on successful completion.
REQ-019 error  output  1  one-cycle pulse on timeout abort.

Function
REQ-020 The block SHALL implement a state machine with the states IDLE, MODE_WR, ENT_WAIT, ENT_WR, START_WR, POLL_RD, LOCK_WAIT.
REQ-021 IDLE: ent_ready=0. The first cycle with ent_valid=1 SHALL set busy=1 and enter MODE_WR; the entry is not consumed.
REQ-022 MODE_WR: the block SHALL drive mgmt_write=1, mgmt_address=0 and mgmt_writedata=MODE_WORD. It SHALL hold these until a cycle with mgmt_waitrequest=0, then go to ENT_WAIT.
REQ-023 ENT_WAIT: ent_ready=1. On ent_valid&ent_ready, the block SHALL latch ent_addr, ent_data and ent_last, then go to ENT_WR. Exactly one entry is accepted per handshake.
REQ-024 ENT_WR: the block SHALL drive the latched address and data with mgmt_write=1 until a cycle with waitrequest=0. It then goes to START_WR if the latched last=1, otherwise back to ENT_WAIT.
REQ-025 START_WR: the block SHALL write address 2, data 0, with the same waitrequest rule. On completion it SHALL clear the timeout counter and go to POLL_RD.
REQ-026 POLL_RD: the block SHALL drive mgmt_read=1 at address 1.
  - On a cycle with waitrequest=0 and mgmt_readdata[0]=1, it SHALL go to LOCK_WAIT.
  - On a cycle with waitrequest=0 and mgmt_readdata[0]=0, it SHALL deassert read for one cycle and then reissue it.
REQ-027 LOCK_WAIT: pll_locked=1 SHALL pulse done, clear busy and return to IDLE.
REQ-028 Timeout counter: 16 bits, saturating. It increments every cycle in POLL_RD and LOCK_WAIT. When it reaches TIMEOUT, the block SHALL pulse error, clear busy, drop mgmt_read and return to IDLE. The timeout check SHALL take priority over a completion arriving in the same cycle.
REQ-029 mgmt_write and mgmt_read SHALL never be high in the same cycle. Address and data SHALL be stable while waitrequest=1.
REQ-030 The minimum latency with waitrequest tied low and status ready immediately is as follows, for one entry and pll_locked already 1: ent_valid at cycle 0 gives done at cycle 6.
REQ-031 Entries with ent_addr=0 or 2 SHALL be written as presented; the block does not filter them.
REQ-032 ent_valid asserted while the block is in any state other than IDLE or ENT_WAIT SHALL be ignored, with ent_ready=0.

Reset
REQ-033 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the timeout counter.
REQ-034 While in reset, these outputs SHALL be 0: mgmt_write, mgmt_read, mgmt_address, mgmt_writedata, ent_ready, busy, done, error.
REQ-035 A reset in mid-transfer SHALL abandon the transfer immediately, even with waitrequest high. No done or error pulse is produced.

Verification
REQ-036 Two entries with waitrequest=0 and status ready immediately:
  - Stimulus: entries (4, 0x0000_0404) then (5, 0x0002_0303, last), pll_locked=1.
  - Response: writes in the order addr 0 / 0x0, 4 / 0x404, 5 / 0x20303, 2 / 0x0; then one read of addr 1; then a done pulse.
REQ-037 Waitrequest stall:
  - Stimulus: hold waitrequest=1 for 5 cycles during an entry write.
  - Response: mgmt_write, mgmt_address and mgmt_writedata are held constant for 6 cycles; no double write occurs.
REQ-038 Status poll:
  - Stimulus: status bit 0 returns 0 three times, then 1.
  - Response: four reads are issued, each separated by one idle cycle, then LOCK_WAIT is entered.
REQ-039 Timeout:
  - Stimulus: TIMEOUT=20, pll_locked held at 0.
  - Response: error pulses exactly 20 cycles after the START_WR write completes; busy falls; no done pulse.
REQ-040 Reset during a stall:
  - Stimulus: rst_n=0 during ENT_WR with waitrequest=1.
  - Response: all outputs are 0 on the next edge. A fresh sequence afterwards begins with the mode write.
